// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite configuration sequencer: FSM encoding,
// table-entry field layout and the default delay marker.
package axil_pkg;

    localparam logic [5:0] S_IDLE  = 6'b000001;
    localparam logic [5:0] S_FETCH = 6'b000010;
    localparam logic [5:0] S_LOAD  = 6'b000100;
    localparam logic [5:0] S_ISSUE = 6'b001000;
    localparam logic [5:0] S_DELAY = 6'b010000;
    localparam logic [5:0] S_DRAIN = 6'b100000;

    typedef enum logic [5:0] {
        ST_IDLE  = S_IDLE,
        ST_FETCH = S_FETCH,
        ST_LOAD  = S_LOAD,
        ST_ISSUE = S_ISSUE,
        ST_DELAY = S_DELAY,
        ST_DRAIN = S_DRAIN
    } state_t;

    localparam int ENT_ADDR_HI = 63;
    localparam int ENT_ADDR_LO = 32;
    localparam int ENT_DATA_HI = 31;
    localparam int ENT_DATA_LO = 0;

    localparam logic [31:0] DELAY_MARK_DEFAULT = 32'hFFFF_FFFF;

    function automatic logic [31:0] ent_addr(input logic [63:0] ent);
        return ent[ENT_ADDR_HI:ENT_ADDR_LO];
    endfunction

    function automatic logic [31:0] ent_data(input logic [63:0] ent);
        return ent[ENT_DATA_HI:ENT_DATA_LO];
    endfunction

endpackage

// File: rtl/axil_cfg_seq.sv
// Walks a table of (address, data) entries and hands each one to the AXI-Lite
// write master as a cfg command; marker entries become timed pauses.
module axil_cfg_seq
    import axil_pkg::*;
#(
    parameter int          IDX_W      = 8,
    parameter logic [31:0] DELAY_MARK = DELAY_MARK_DEFAULT
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_areset,
    input  logic             start,
    input  logic [IDX_W:0]   seq_len,
    output logic             tbl_rd,
    output logic [IDX_W-1:0] tbl_addr,
    input  logic [63:0]      tbl_rdata,
    output logic             s_axi_cfg_wvalid,
    output logic [31:0]      s_axi_cfg_waddr,
    output logic [31:0]      s_axi_cfg_wdata,
    input  logic             s_axi_cfg_wready,
    output logic             busy,
    output logic             done,
    output logic [IDX_W:0]   wr_count
);

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W:0]   len_r;
    logic [31:0]      dly_r;

    logic [31:0]      ent_addr_s;
    logic [31:0]      ent_data_s;
    logic             is_mark_s;
    logic             last_s;
    logic             xfer_s;
    logic             advance_s;
    logic [IDX_W-1:0] idx_next_s;

    assign ent_addr_s = ent_addr(tbl_rdata);
    assign ent_data_s = ent_data(tbl_rdata);
    assign is_mark_s  = (ent_addr_s == DELAY_MARK);
    assign xfer_s     = s_axi_cfg_wvalid & s_axi_cfg_wready;
    assign last_s     = ({1'b0, idx_r} == (len_r - (IDX_W+1)'(1'b1)));
    assign idx_next_s = idx_r + IDX_W'(1'b1);

    // Current entry is finished: zero-length pause, accepted write or expiring pause.
    always_comb begin
        advance_s = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (is_mark_s && (ent_data_s == 32'd0)) begin
                    advance_s = 1'b1;
                end else begin
                    advance_s = 1'b0;
                end
            end
            ST_ISSUE: advance_s = xfer_s;
            ST_DELAY: advance_s = (dly_r == 32'd1);
            default:  advance_s = 1'b0;
        endcase
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_r          <= ST_IDLE;
            idx_r            <= {IDX_W{1'b0}};
            len_r            <= {(IDX_W+1){1'b0}};
            dly_r            <= 32'd0;
            tbl_rd           <= 1'b0;
            tbl_addr         <= {IDX_W{1'b0}};
            s_axi_cfg_wvalid <= 1'b0;
            s_axi_cfg_waddr  <= 32'd0;
            s_axi_cfg_wdata  <= 32'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            wr_count         <= {(IDX_W+1){1'b0}};
        end else begin
            tbl_rd <= 1'b0;
            done   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        wr_count <= {(IDX_W+1){1'b0}};
                        if (seq_len == {(IDX_W+1){1'b0}}) begin
                            done <= 1'b1;
                        end else begin
                            len_r    <= seq_len;
                            idx_r    <= {IDX_W{1'b0}};
                            tbl_rd   <= 1'b1;
                            tbl_addr <= {IDX_W{1'b0}};
                            busy     <= 1'b1;
                            state_r  <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: state_r <= ST_LOAD;
                ST_LOAD: begin
                    if (is_mark_s) begin
                        if (ent_data_s != 32'd0) begin
                            dly_r   <= ent_data_s;
                            state_r <= ST_DELAY;
                        end
                    end else begin
                        s_axi_cfg_waddr  <= ent_addr_s;
                        s_axi_cfg_wdata  <= ent_data_s;
                        s_axi_cfg_wvalid <= 1'b1;
                        state_r          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (xfer_s) begin
                        s_axi_cfg_wvalid <= 1'b0;
                        wr_count         <= wr_count + (IDX_W+1)'(1'b1);
                    end
                end
                ST_DELAY: dly_r <= dly_r - 32'd1;
                ST_DRAIN: begin
                    // wready high again means the last B response has been consumed.
                    if (s_axi_cfg_wready) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    s_axi_cfg_wvalid <= 1'b0;
                    busy             <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase

            if (advance_s) begin
                if (last_s) begin
                    state_r <= ST_DRAIN;
                end else begin
                    idx_r    <= idx_next_s;
                    tbl_addr <= idx_next_s;
                    tbl_rd   <= 1'b1;
                    state_r  <= ST_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_cfg_seq.sv
// Bench for axil_cfg_seq: directed vector table, hand-written corner sequences
// and randomized tables checked against a cycle-level behavioural model.
module tb_axil_cfg_seq;
    import axil_pkg::*;

    localparam int          IDX_W = 8;
    localparam logic [31:0] DM    = 32'hFFFF_FFFF;

    logic             s_axi_aclk = 1'b0;
    logic             s_axi_areset;
    logic             start;
    logic [IDX_W:0]   seq_len;
    logic             tbl_rd;
    logic [IDX_W-1:0] tbl_addr;
    logic [63:0]      tbl_rdata = 64'd0;
    logic             s_axi_cfg_wvalid;
    logic [31:0]      s_axi_cfg_waddr;
    logic [31:0]      s_axi_cfg_wdata;
    logic             s_axi_cfg_wready = 1'b1;
    logic             busy;
    logic             done;
    logic [IDX_W:0]   wr_count;

    always #5 s_axi_aclk = ~s_axi_aclk;

    axil_cfg_seq #(.IDX_W(IDX_W), .DELAY_MARK(DM)) dut (
        .s_axi_aclk       (s_axi_aclk),
        .s_axi_areset     (s_axi_areset),
        .start            (start),
        .seq_len          (seq_len),
        .tbl_rd           (tbl_rd),
        .tbl_addr         (tbl_addr),
        .tbl_rdata        (tbl_rdata),
        .s_axi_cfg_wvalid (s_axi_cfg_wvalid),
        .s_axi_cfg_waddr  (s_axi_cfg_waddr),
        .s_axi_cfg_wdata  (s_axi_cfg_wdata),
        .s_axi_cfg_wready (s_axi_cfg_wready),
        .busy             (busy),
        .done             (done),
        .wr_count         (wr_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;

    typedef struct {
        int          n;
        int          lat;
        logic [63:0] e [3];
        int          exp_wr;
        int          exp_dly;
        int          exp_gap;
    } vec_t;

    logic [63:0] mem [0:255];
    int  cyc = 0;
    int  lat = 2;
    bit  bp  = 1'b0;
    int  n_pass = 0;
    int  n_tot  = 0;

    wr_t wr_q [$];
    int  rd_q [$];
    int  rdc_q [$];
    int  done_q [$];
    bit  dbusy_q [$];
    bit  dprev_q [$];

    // Write-master model, table ROM and passive monitor in one cycle loop.
    int  busy_cnt = 0;
    bit  xfer_m, rd_p, prev_busy;
    logic [IDX_W-1:0] rd_a;
    wr_t wtmp;
    always begin
        @(negedge s_axi_aclk);
        xfer_m = s_axi_cfg_wvalid && s_axi_cfg_wready;
        if (xfer_m) begin
            wtmp.a = s_axi_cfg_waddr;
            wtmp.d = s_axi_cfg_wdata;
            wtmp.c = cyc;
            wr_q.push_back(wtmp);
        end
        rd_p = tbl_rd;
        rd_a = tbl_addr;
        if (tbl_rd) begin
            rd_q.push_back(int'(tbl_addr));
            rdc_q.push_back(cyc);
        end
        if (done) begin
            done_q.push_back(cyc);
            dbusy_q.push_back(busy);
            dprev_q.push_back(prev_busy);
        end
        prev_busy = busy;
        @(posedge s_axi_aclk);
        cyc++;
        #1;
        if (s_axi_areset) busy_cnt = 0;
        else if (xfer_m) busy_cnt = lat;
        else if (busy_cnt > 0) busy_cnt--;
        s_axi_cfg_wready = (busy_cnt == 0) && !bp;
        tbl_rdata = rd_p ? mem[rd_a] : {$urandom, $urandom};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic pulse_start(input int n, output int s);
        @(posedge s_axi_aclk); #1;
        start   = 1'b1;
        seq_len = n[IDX_W:0];
        s       = cyc;
        @(posedge s_axi_aclk); #1;
        start   = 1'b0;
        seq_len = 9'($urandom_range(0, 511));
    endtask

    task automatic wait_done(input int db, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            @(posedge s_axi_aclk);
            if (done_q.size() > db) break;
        end
        if (i == bound) chk("done_timeout", 64'd0, 64'd1);
        repeat (5) @(posedge s_axi_aclk);
        #1;
    endtask

    // Timing reference: walks entries with a cycle cursor and master-ready time.
    function automatic void model(input int n, input int l, output int nw, output int dly);
        int t, rdy, x;
        t = 1; rdy = 0; nw = 0;
        for (int i = 0; i < n; i++) begin
            if (ent_addr(mem[i]) == DM) begin
                t = t + 2 + int'(ent_data(mem[i]));
            end else begin
                x   = (t + 2 > rdy) ? t + 2 : rdy;
                rdy = x + l + 1;
                t   = x + 1;
                nw++;
            end
        end
        dly = (n == 0) ? 1 : (((t > rdy) ? t : rdy) + 1);
    endfunction

    task automatic run_check(input string nm, input int n, input int l,
                             input int exp_wr, input int exp_dly, input int exp_gap);
        int s, wb, rb, db, k;
        wr_t ew [$];
        wr_t e;
        lat = l;
        repeat (20) @(posedge s_axi_aclk);
        wb = wr_q.size(); rb = rd_q.size(); db = done_q.size();
        pulse_start(n, s);
        wait_done(db, 600);
        for (int i = 0; i < n; i++) begin
            if (ent_addr(mem[i]) != DM) begin
                e.a = ent_addr(mem[i]); e.d = ent_data(mem[i]); e.c = 0;
                ew.push_back(e);
            end
        end
        chk({nm, " done_cnt"}, done_q.size() - db, 1);
        if (done_q.size() > db) begin
            chk({nm, " done_lat"}, done_q[db] - s, exp_dly);
            chk({nm, " busy_at_done"}, dbusy_q[db], 0);
            chk({nm, " busy_before_done"}, dprev_q[db], n > 0);
        end
        chk({nm, " rd_cnt"}, rd_q.size() - rb, n);
        k = (rd_q.size() - rb < n) ? rd_q.size() - rb : n;
        for (int i = 0; i < k; i++) chk({nm, " rd_addr"}, rd_q[rb+i], i);
        if (k > 0) chk({nm, " first_rd"}, rdc_q[rb] - s, 1);
        chk({nm, " wr_num"}, wr_q.size() - wb, exp_wr);
        chk({nm, " wr_model"}, ew.size(), exp_wr);
        k = (wr_q.size() - wb < ew.size()) ? wr_q.size() - wb : ew.size();
        for (int i = 0; i < k; i++) begin
            chk({nm, " waddr"}, wr_q[wb+i].a, ew[i].a);
            chk({nm, " wdata"}, wr_q[wb+i].d, ew[i].d);
        end
        if (exp_gap > 0 && wr_q.size() - wb >= 2)
            chk({nm, " gap"}, wr_q[wb+1].c - wr_q[wb].c, exp_gap);
        chk({nm, " wr_count"}, wr_count, exp_wr);
    endtask

    vec_t vt [7];

    task automatic set_vec(input int i, input int n, input int l, input logic [63:0] e0,
                           input logic [63:0] e1, input logic [63:0] e2,
                           input int w, input int d, input int g);
        vt[i].n = n; vt[i].lat = l;
        vt[i].e[0] = e0; vt[i].e[1] = e1; vt[i].e[2] = e2;
        vt[i].exp_wr = w; vt[i].exp_dly = d; vt[i].exp_gap = g;
    endtask

    initial begin
        int s, wb, db, nw, dly, n, l;
        logic [31:0] a0, d0;
        start = 1'b0; seq_len = '0; s_axi_areset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 64'd0;

        set_vec(0, 2, 6, {32'h10, 32'hA5}, {32'h14, 32'h5A}, 64'd0, 2, 18, 7);
        set_vec(1, 3, 4, {32'h20, 32'h1}, {DM, 32'h5}, {32'h24, 32'h2}, 2, 19, 10);
        set_vec(2, 2, 2, {32'h30, 32'h7}, {DM, 32'h3}, 64'd0, 1, 10, 0);
        set_vec(3, 3, 1, {DM, 32'h0}, {32'h40, 32'h11}, {DM, 32'h0}, 1, 9, 0);
        set_vec(4, 0, 1, {32'h99, 32'h99}, 64'd0, 64'd0, 0, 1, 0);
        set_vec(5, 1, 1, {DM, 32'h2}, 64'd0, 64'd0, 0, 6, 0);
        set_vec(6, 1, 3, {32'h50, 32'h1}, {32'h54, 32'h2}, 64'd0, 1, 8, 0);

        repeat (3) @(posedge s_axi_aclk);
        #1;
        chk("reset_outputs", {tbl_rd, tbl_addr, s_axi_cfg_wvalid, s_axi_cfg_waddr,
                              s_axi_cfg_wdata, busy, done, wr_count}, 64'd0);
        @(negedge s_axi_aclk);
        s_axi_areset = 1'b0;

        foreach (vt[v]) begin
            for (int j = 0; j < 3; j++) mem[j] = vt[v].e[j];
            run_check($sformatf("vec%0d", v), vt[v].n, vt[v].lat,
                      vt[v].exp_wr, vt[v].exp_dly, vt[v].exp_gap);
        end

        // Back-pressure in ISSUE plus a start pulse that must be ignored.
        mem[0] = {32'h60, 32'hBEEF}; mem[1] = {32'h64, 32'h1234};
        lat = 2;
        @(negedge s_axi_aclk); bp = 1'b1;
        repeat (20) @(posedge s_axi_aclk);
        wb = wr_q.size(); db = done_q.size();
        pulse_start(2, s);
        for (int i = 0; i < 20; i++) begin
            @(negedge s_axi_aclk);
            if (s_axi_cfg_wvalid) break;
        end
        a0 = s_axi_cfg_waddr; d0 = s_axi_cfg_wdata;
        chk("bp wvalid_seen", s_axi_cfg_wvalid, 1);
        chk("bp first_addr", a0, 32'h60);
        for (int i = 0; i < 10; i++) begin
            @(negedge s_axi_aclk);
            chk("bp wvalid_hold", s_axi_cfg_wvalid, 1);
            chk("bp waddr_hold", s_axi_cfg_waddr, a0);
            chk("bp wdata_hold", s_axi_cfg_wdata, d0);
            start   = (i == 3);
            seq_len = 9'd1;
        end
        start = 1'b0;
        chk("bp no_xfer", wr_q.size() - wb, 0);
        bp = 1'b0;
        wait_done(db, 200);
        chk("bp xfer_cnt", wr_q.size() - wb, 2);
        if (wr_q.size() - wb >= 2) begin
            chk("bp wdata0", wr_q[wb].d, 32'hBEEF);
            chk("bp waddr1", wr_q[wb+1].a, 32'h64);
        end
        chk("bp done_cnt", done_q.size() - db, 1);
        chk("bp wr_count", wr_count, 2);

        // Asynchronous reset while entry 1 of 3 waits in ISSUE.
        mem[0] = {32'h70, 32'h1}; mem[1] = {32'h74, 32'h2}; mem[2] = {32'h78, 32'h3};
        repeat (20) @(posedge s_axi_aclk);
        wb = wr_q.size(); db = done_q.size();
        pulse_start(3, s);
        for (int i = 0; i < 30; i++) begin
            @(posedge s_axi_aclk);
            if (wr_q.size() > wb) break;
        end
        @(negedge s_axi_aclk); bp = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge s_axi_aclk);
            if (s_axi_cfg_wvalid && s_axi_cfg_waddr == 32'h74) break;
        end
        chk("rst in_issue1", {s_axi_cfg_wvalid, s_axi_cfg_waddr}, {1'b1, 32'h74});
        s_axi_areset = 1'b1;
        #1;
        chk("rst outputs", {tbl_rd, tbl_addr, s_axi_cfg_wvalid, s_axi_cfg_waddr,
                            s_axi_cfg_wdata, busy, done, wr_count}, 64'd0);
        repeat (3) @(negedge s_axi_aclk);
        s_axi_areset = 1'b0;
        repeat (10) @(negedge s_axi_aclk);
        chk("rst no_done", done_q.size() - db, 0);
        bp = 1'b0;
        model(3, 2, nw, dly);
        run_check("rerun", 3, 2, nw, dly, 0);

        // Randomized tables against the behavioural model.
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(1, 6);
            l = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) < 3) mem[i] = {DM, 32'($urandom_range(0, 4))};
                else mem[i] = {32'($urandom_range(0, 32'hFFFF_FFFE)), $urandom};
            end
            model(n, l, nw, dly);
            run_check($sformatf("rnd%0d", r), n, l, nw, dly, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
